// File: rtl/sixbit_mul_seq_pkg.sv
// Calculator-wide constants shared by the sequential multiplier and the divider.
// Holds the datapath width, the signed result range and the multiplier FSM encoding.
package sixbit_mul_seq_pkg;

  localparam int unsigned CALC_W   = 6;
  localparam int          CALC_MIN = -32;
  localparam int          CALC_MAX = 31;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } mul_state_e;

endpackage

// File: rtl/twos_abs.sv
// Conditional two's-complement negate: passes val through, or returns -val when neg is set.
module twos_abs #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/sixbit_mul_seq.sv
// Sequential signed multiplier: sign/magnitude shift-and-add over WIDTH cycles,
// returning the truncated product and an out-of-range flag through start/busy/done.
module sixbit_mul_seq
  import sixbit_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AccW = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic signed [AccW-1:0] ResMin = AccW'(CALC_MIN);
  localparam logic signed [AccW-1:0] ResMax = AccW'(CALC_MAX);

  mul_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [AccW-1:0]  acc_q;
  logic             sign_q;
  logic [WIDTH-1:0] mag_a_q;
  logic [WIDTH-1:0] mag_b_q;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [AccW-1:0]  res;
  logic [AccW-1:0]  addend;
  logic             res_ovf;

  // Magnitudes are unsigned, so |-32| stays representable as 6'b100000.
  twos_abs #(.W(WIDTH)) u_abs_a (
    .val (multiplicand),
    .neg (multiplicand[WIDTH-1]),
    .res (mag_a)
  );

  twos_abs #(.W(WIDTH)) u_abs_b (
    .val (multiplier),
    .neg (multiplier[WIDTH-1]),
    .res (mag_b)
  );

  twos_abs #(.W(AccW)) u_sign_res (
    .val (acc_q),
    .neg (sign_q),
    .res (res)
  );

  assign addend = {{WIDTH{1'b0}}, mag_a_q} << cnt_q;

  // The accumulator never exceeds 32*32, so the signed range check on res matches
  // acc > 32 for negative results and acc > 31 for non-negative ones.
  assign res_ovf = ($signed(res) < ResMin) || ($signed(res) > ResMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      product <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sign_q  <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
            mag_a_q <= mag_a;
            mag_b_q <= mag_b;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (mag_b_q[cnt_q]) begin
            acc_q <= acc_q + addend;
          end
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          product <= res[WIDTH-1:0];
          err     <= res_ovf;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
